// File: rtl/counter_run_controller_pkg.sv
// Shared state encodings and default divider/limit constants for the LED counter run controller.
package counter_run_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSE  = 2'b10,
        ST_RELOAD = 2'b11
    } state_t;

    localparam logic [29:0] PERIOD_0_DEF        = 30'd25_000_000;
    localparam logic [29:0] PERIOD_1_DEF        = 30'd12_500_000;
    localparam logic [29:0] PERIOD_2_DEF        = 30'd6_250_000;
    localparam logic [29:0] PERIOD_3_DEF        = 30'd2_500_000;
    localparam logic [7:0]  LIMIT_DEFAULT_DEF   = 8'h00;
    localparam int          DEBOUNCE_CYCLES_DEF = 1_000_000;

    function automatic logic [1:0] next_speed(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/counter_run_controller_button_press_detect.sv
// Button synchronizer + rising-edge press pulse; optional level debounce when DEBOUNCE_EN is defined.
module button_press_detect
    import counter_run_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_press;
    logic w_level;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_stable;
    logic [CW-1:0] r_cnt;

    // Reload whenever the synchronized level matches the accepted one, so only an unbroken run counts.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stable <= 1'b0;
            r_cnt    <= LOAD;
        end else if (r_sync2 == r_stable) begin
            r_cnt <= LOAD;
        end else if (r_cnt == '0) begin
            r_stable <= r_sync2;
            r_cnt    <= LOAD;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign w_level = r_stable;
`else
    assign w_level = r_sync2;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev  <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_prev  <= w_level;
            r_press <= w_level & ~r_prev;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/counter_run_controller.sv
// Run/speed/limit controller for the LED divider/counter pair. Optional macro: DEBOUNCE_EN.
// state  | meaning
// IDLE   | stopped, counter cleared or never started
// RUN    | counter enabled
// PAUSE  | counter held, value kept
// RELOAD | one-cycle gap while the divider takes a new period
module counter_run_controller
    import counter_run_controller_pkg::*;
#(
    parameter logic [29:0] PERIOD_0        = PERIOD_0_DEF,
    parameter logic [29:0] PERIOD_1        = PERIOD_1_DEF,
    parameter logic [29:0] PERIOD_2        = PERIOD_2_DEF,
    parameter logic [29:0] PERIOD_3        = PERIOD_3_DEF,
    parameter logic [7:0]  LIMIT_DEFAULT   = LIMIT_DEFAULT_DEF,
    parameter int          DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic        CLK_50M,
    input  logic        RESET,
    input  logic        BTN_START,
    input  logic        BTN_SPEED,
    input  logic        BTN_CLEAR,
    input  logic        BTN_LIMIT,
    input  logic [7:0]  SW,
    output logic [29:0] PERIOD,
    output logic [7:0]  LIMIT,
    output logic        RUN,
    output logic        CLEAR,
    output logic [1:0]  SPEED_IDX,
    output logic [1:0]  STATE
);

    logic w_p_start, w_p_speed, w_p_clear, w_p_limit;
    logic w_do_clear, w_do_start, w_do_speed, w_do_limit;

    state_t      r_state, w_state_nxt;
    logic        r_run, r_clear;
    logic [1:0]  r_speed, w_speed_nxt;
    logic [29:0] r_period;
    logic [7:0]  r_limit, w_limit_nxt;

    button_press_detect #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_start (
        .i_clk(CLK_50M), .i_rst(RESET), .i_btn(BTN_START), .o_press(w_p_start));
    button_press_detect #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_speed (
        .i_clk(CLK_50M), .i_rst(RESET), .i_btn(BTN_SPEED), .o_press(w_p_speed));
    button_press_detect #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clear (
        .i_clk(CLK_50M), .i_rst(RESET), .i_btn(BTN_CLEAR), .o_press(w_p_clear));
    button_press_detect #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_limit (
        .i_clk(CLK_50M), .i_rst(RESET), .i_btn(BTN_LIMIT), .o_press(w_p_limit));

    // Only the highest-priority press of a cycle is acted on.
    assign w_do_clear = w_p_clear;
    assign w_do_start = w_p_start & ~w_p_clear;
    assign w_do_speed = w_p_speed & ~w_p_clear & ~w_p_start;
    assign w_do_limit = w_p_limit & ~w_p_clear & ~w_p_start & ~w_p_speed;

    function automatic logic [29:0] period_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return PERIOD_0;
            2'd1:    return PERIOD_1;
            2'd2:    return PERIOD_2;
            default: return PERIOD_3;
        endcase
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_speed_nxt = r_speed;
        w_limit_nxt = r_limit;
        case (r_state)
            ST_IDLE:   if (w_do_start) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (w_do_start)      w_state_nxt = ST_PAUSE;
                else if (w_do_speed) w_state_nxt = ST_RELOAD;
            end
            ST_PAUSE:  if (w_do_start) w_state_nxt = ST_RUN;
            ST_RELOAD: w_state_nxt = w_do_start ? ST_PAUSE : ST_RUN;
            default:   w_state_nxt = ST_IDLE;
        endcase
        if (w_do_clear) w_state_nxt = ST_IDLE;
        if (w_do_speed) w_speed_nxt = next_speed(r_speed);
        if (w_do_limit) w_limit_nxt = SW;
    end

    always_ff @(posedge CLK_50M or posedge RESET) begin
        if (RESET) begin
            r_state  <= ST_IDLE;
            r_run    <= 1'b0;
            r_clear  <= 1'b0;
            r_speed  <= 2'd0;
            r_period <= PERIOD_0;
            r_limit  <= LIMIT_DEFAULT;
        end else begin
            r_state  <= w_state_nxt;
            r_run    <= (w_state_nxt == ST_RUN);
            r_clear  <= w_do_clear;
            r_speed  <= w_speed_nxt;
            r_period <= period_of(w_speed_nxt);
            r_limit  <= w_limit_nxt;
        end
    end

    assign STATE     = r_state;
    assign RUN       = r_run;
    assign CLEAR     = r_clear;
    assign SPEED_IDX = r_speed;
    assign PERIOD    = r_period;
    assign LIMIT     = r_limit;

endmodule
